// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//
// Reset/lock supervisor for up to 8 PLLs that share one reference clock.
// Holds every PLL in reset, releases them after a timed reset pulse, and waits
// until all locked flags are high. The flags must then stay high for a
// stability window before ready asserts. If the flags do not settle in time,
// the sequence is retried a bounded number of times and then parks in FAIL.
// A lock loss while ready re-runs the whole sequence and is counted.
//
// Ports
//   refclk        in   reference clock, the only clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   1 = run the sequence, 0 = hold PLLs in reset (IDLE)
//   pll_locked    in   raw per-PLL locked flags, asynchronous to refclk
//   pll_rst       out  active-high reset to all PLLs
//   ready         out  all PLLs locked and stable
//   fail          out  retries exhausted; sticky until enable drops
//   retry_count   out  timeout retries used in the current enable session
//   lock_lost_cnt out  READY->lock-loss events, saturating at 255
//   state         out  FSM state: IDLE=0 RESET=1 WAIT_LOCK=2 STABLE=3
//                      READY=4 FAIL=5
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int NUM_PLLS            = 1,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 4
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_PLLS-1:0] pll_locked,
    output logic                pll_rst,
    output logic                ready,
    output logic                fail,
    output logic [3:0]          retry_count,
    output logic [7:0]          lock_lost_cnt,
    output logic [2:0]          state
);

    // Each counter is one bit wider than its terminal value needs; every
    // counter clears on entry to its state, so it can never wrap.
    localparam int RST_W = $clog2(RST_PULSE_CYCLES) + 1;
    localparam int ST_W  = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_PULSE_CYCLES - 1);
    localparam logic [ST_W-1:0]  ST_LAST   = ST_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [RST_W-1:0]     rst_cnt_q;
    logic [RST_W-1:0]     rst_cnt_d;
    logic [TO_W-1:0]      to_cnt_q;
    logic [TO_W-1:0]      to_cnt_d;
    logic [ST_W-1:0]      st_cnt_q;
    logic [ST_W-1:0]      st_cnt_d;
    logic [3:0]           retry_d;
    logic [7:0]           lost_d;
    logic [NUM_PLLS-1:0]  lk_sync_p0;
    logic [NUM_PLLS-1:0]  lk_sync_p1;
    logic                 all_lk;
    logic                 timeout;

    // Saturating increment for the lock-loss event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---- stage p0/p1: two-flop synchroniser for the raw locked flags ----
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lk_sync_p0 <= '0;
            lk_sync_p1 <= '0;
        end else begin
            lk_sync_p0 <= pll_locked;
            lk_sync_p1 <= lk_sync_p0;
        end
    end

    assign all_lk = &lk_sync_p1;

    // ---- FSM next-state and counter updates ----
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        st_cnt_d  = st_cnt_q;
        retry_d   = retry_count;
        lost_d    = lock_lost_cnt;
        timeout   = (to_cnt_q == TO_LAST);

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESET;
                end
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (timeout) begin
                        if (retry_count < RETRY_MAX) begin
                            retry_d = retry_count + 4'd1;
                            state_d = ST_RESET;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else if (all_lk) begin
                        state_d = ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    // Timeout wins over a same-cycle completion of the
                    // stability window.
                    if (timeout) begin
                        if (retry_count < RETRY_MAX) begin
                            retry_d = retry_count + 4'd1;
                            state_d = ST_RESET;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else if (!all_lk) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (st_cnt_q == ST_LAST) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (!all_lk) begin
                        state_d = ST_RESET;
                        lost_d  = sat_inc8(lock_lost_cnt);
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Reset-pulse counter: zero outside RESET, counts while in it.
        if (state_q == ST_RESET) begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
        end else begin
            rst_cnt_d = '0;
        end

        // Timeout counter spans WAIT_LOCK and STABLE; it is held at zero
        // during RESET so it starts from zero on entry to WAIT_LOCK, and a
        // STABLE->WAIT_LOCK fallback keeps the running count.
        if (state_q == ST_RESET) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT_LOCK || state_q == ST_STABLE) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        // Stability counter is zero whenever we are not in STABLE, so a
        // registered glitch that drops back to WAIT_LOCK restarts the window.
        if (state_q != ST_STABLE) begin
            st_cnt_d = '0;
        end else if (all_lk) begin
            st_cnt_d = st_cnt_q + ST_W'(1);
        end

        if (state_d == ST_IDLE) begin
            retry_d = 4'd0;
        end
    end

    // ---- stage p2: state, counters and registered outputs ----
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= '0;
            to_cnt_q      <= '0;
            st_cnt_q      <= '0;
            retry_count   <= 4'd0;
            lock_lost_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            to_cnt_q      <= to_cnt_d;
            st_cnt_q      <= st_cnt_d;
            retry_count   <= retry_d;
            lock_lost_cnt <= lost_d;
            // Outputs decode the next state so they change on the same edge
            // as the state register.
            pll_rst       <= (state_d == ST_IDLE) || (state_d == ST_RESET) ||
                             (state_d == ST_FAIL);
            ready         <= (state_d == ST_READY);
            fail          <= (state_d == ST_FAIL);
        end
    end

    assign state = state_q;

endmodule
